// File: rtl/floating_divider_if.sv
// Start/busy/done handshake and operand/result bundle for floating_divider.
// With FDIV_EXCEPT_EN defined the bundle also carries overflow/underflow.
interface floating_divider_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] out;
  logic        div_by_zero;
`ifdef FDIV_EXCEPT_EN
  logic        overflow;
  logic        underflow;

  modport master (output start, a, b,
                  input  busy, done, out, div_by_zero, overflow, underflow);
  modport slave  (input  start, a, b,
                  output busy, done, out, div_by_zero, overflow, underflow);
`else
  modport master (output start, a, b,
                  input  busy, done, out, div_by_zero);
  modport slave  (input  start, a, b,
                  output busy, done, out, div_by_zero);
`endif
endinterface

// File: rtl/floating_divider.sv
// Iterative IEEE-754 single divider: restoring division, one quotient bit per clock.
// Optional FDIV_EXCEPT_EN adds saturating overflow/underflow flags; otherwise the exponent wraps.
module floating_divider #(
  parameter int BIAS = 127
) (
  input  logic              clk,
  input  logic              rst_n,
  floating_divider_if.slave bus
);
`ifdef FDIV_EXCEPT_EN
  localparam int EW = 10;
`else
  localparam int EW = 8;
`endif
  localparam logic [4:0] LAST = 5'd25;

  typedef enum logic [1:0] {IDLE, DIV, NORM} state_t;

  state_t        state, state_nxt;
  logic          load, busy, done;
  logic          sign_q, a_zero_q, b_zero_q;
  logic [EW-1:0] exp_q, exp_n;
  logic [23:0]   mb_q;
  logic [24:0]   rem_q, rem_nxt;
  logic [23:0]   rem_sub;
  logic [24:0]   quo_q, quo_nxt;
  logic [4:0]    cnt_q;
  logic          ge;
  logic [22:0]   frac;
  logic [31:0]   out_q, res;
  logic          dz_q, res_dz;
`ifdef FDIV_EXCEPT_EN
  logic          ovf_q, unf_q, res_ovf, res_unf;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // DIV holds 26 cycles: 25 quotient bits, then the normalized result is
  // registered on the edge that enters NORM so it is valid alongside done.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: if (bus.start) begin
        load      = 1'b1;
        state_nxt = DIV;
      end
      DIV: begin
        busy = 1'b1;
        if (cnt_q == LAST) state_nxt = NORM;
      end
      NORM: begin
        done = 1'b1;
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = DIV;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Remainder stays below 2*mb, so 25 bits hold it after the shift.
  always_comb begin
    ge      = rem_q >= {1'b0, mb_q};
    rem_sub = ge ? 24'(rem_q - {1'b0, mb_q}) : rem_q[23:0];
    rem_nxt = {rem_sub, 1'b0};
    quo_nxt = {quo_q[23:0], ge};
  end

  always_comb begin
    exp_n   = quo_q[24] ? exp_q : exp_q - EW'(1);
    frac    = quo_q[24] ? quo_q[23:1] : quo_q[22:0];
    res     = {sign_q, exp_n[7:0], frac};
    res_dz  = 1'b0;
`ifdef FDIV_EXCEPT_EN
    res_ovf = 1'b0;
    res_unf = 1'b0;
`endif
    if (b_zero_q) begin
      res    = {sign_q, 8'hFF, 23'h0};
      res_dz = 1'b1;
    end else if (a_zero_q) begin
      res    = {sign_q, 31'h0};
    end
`ifdef FDIV_EXCEPT_EN
    else if ($signed(exp_n) > 10'sd254) begin
      res     = {sign_q, 8'hFF, 23'h0};
      res_ovf = 1'b1;
    end else if ($signed(exp_n) < 10'sd1) begin
      res     = {sign_q, 31'h0};
      res_unf = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_q   <= 1'b0;
      a_zero_q <= 1'b0;
      b_zero_q <= 1'b0;
      exp_q    <= '0;
      mb_q     <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
      dz_q     <= 1'b0;
`ifdef FDIV_EXCEPT_EN
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
`endif
    end else if (load) begin
      sign_q   <= bus.a[31] ^ bus.b[31];
      a_zero_q <= bus.a[30:0] == 31'h0;
      b_zero_q <= bus.b[30:0] == 31'h0;
      exp_q    <= EW'({2'b00, bus.a[30:23]} - {2'b00, bus.b[30:23]} + 10'(BIAS));
      mb_q     <= {1'b1, bus.b[22:0]};
      rem_q    <= {2'b01, bus.a[22:0]};
      quo_q    <= '0;
      cnt_q    <= '0;
    end else if (state == DIV) begin
      if (cnt_q != LAST) begin
        rem_q <= rem_nxt;
        quo_q <= quo_nxt;
        cnt_q <= cnt_q + 5'd1;
      end else begin
        out_q <= res;
        dz_q  <= res_dz;
`ifdef FDIV_EXCEPT_EN
        ovf_q <= res_ovf;
        unf_q <= res_unf;
`endif
      end
    end
  end

  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.out         = out_q;
  assign bus.div_by_zero = dz_q;
`ifdef FDIV_EXCEPT_EN
  assign bus.overflow    = ovf_q;
  assign bus.underflow   = unf_q;
`endif
endmodule

// File: tb/tb_floating_divider.sv
// Randomized bench for floating_divider: arithmetic reference model plus
// directed literal cases for latency, zero operands, ignored start and reset.
module tb_floating_divider;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  bit   chk_en = 1'b0;

  floating_divider_if fif();

  floating_divider #(.BIAS(127)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (fif)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: integer division of the hidden-one mantissas, then the
  // normalization and zero/exception rules applied on plain ints.
  function automatic logic [31:0] model_div(input logic [31:0] x, input logic [31:0] y,
                                            output logic dz, output logic ov, output logic un);
    longint ma, mb, q;
    int e;
    logic s;
    logic [22:0] fr;
    logic [31:0] ev;
    s = x[31] ^ y[31];
    dz = 1'b0; ov = 1'b0; un = 1'b0;
    if (y[30:0] == 31'h0) begin
      dz = 1'b1;
      return {s, 8'hFF, 23'h0};
    end
    if (x[30:0] == 31'h0) return {s, 31'h0};
    ma = longint'({1'b1, x[22:0]});
    mb = longint'({1'b1, y[22:0]});
    q  = (ma << 24) / mb;
    e  = int'(x[30:23]) - int'(y[30:23]) + 127;
    if (q >= (64'sd1 << 24)) fr = 23'((q >> 1) & 64'h7FFFFF);
    else begin
      fr = 23'(q & 64'h7FFFFF);
      e  = e - 1;
    end
`ifdef FDIV_EXCEPT_EN
    if (e > 254) begin ov = 1'b1; return {s, 8'hFF, 23'h0}; end
    if (e < 1)   begin un = 1'b1; return {s, 31'h0}; end
`endif
    ev = e;
    return {s, ev[7:0], fr};
  endfunction

  // Handshake model: -1 idle, 0..25 busy cycles after the load edge, 26 = done cycle.
  int          m_cnt = -1;
  logic [31:0] m_a, m_b, m_out = '0;
  logic        m_dz = 1'b0, m_ov = 1'b0, m_un = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = -1; m_out = '0; m_dz = 1'b0; m_ov = 1'b0; m_un = 1'b0;
    end else if (m_cnt == -1 || m_cnt == 26) begin
      if (fif.start === 1'b1) begin
        m_a = fif.a; m_b = fif.b; m_cnt = 0;
      end else m_cnt = -1;
    end else begin
      m_cnt++;
      if (m_cnt == 26) m_out = model_div(m_a, m_b, m_dz, m_ov, m_un);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 32'(fif.busy), 32'(m_cnt >= 0 && m_cnt <= 25));
      check("done", 32'(fif.done), 32'(m_cnt == 26));
      check("out", fif.out, m_out);
      check("div_by_zero", 32'(fif.div_by_zero), 32'(m_dz));
`ifdef FDIV_EXCEPT_EN
      check("overflow", 32'(fif.overflow), 32'(m_ov));
      check("underflow", 32'(fif.underflow), 32'(m_un));
`endif
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (fif.done !== 1'b1 && n < 60) begin tick(1); n++; end
    check("done_seen", 32'(fif.done), 32'd1);
  endtask

  task automatic do_div(input logic [31:0] aa, input logic [31:0] bb, input bit lit,
                        input logic [31:0] exp_out, input logic exp_dz);
    int n;
    fif.start = 1'b1; fif.a = aa; fif.b = bb;
    tick(1);
    fif.start = 1'b0; fif.a = $urandom; fif.b = $urandom;
    wait_done(n);
    check("latency", 32'(n), 32'd26);
    if (lit) begin
      check("out_lit", fif.out, exp_out);
      check("dz_lit", 32'(fif.div_by_zero), 32'(exp_dz));
    end
  endtask

  initial begin
    int n;
    bit seen;
    logic [31:0] ra, rb;
    fif.start = 1'b0; fif.a = '0; fif.b = '0;
    tick(2);
    check("rst_busy", 32'(fif.busy), 32'd0);
    check("rst_done", 32'(fif.done), 32'd0);
    check("rst_out", fif.out, 32'h0);
    check("rst_dz", 32'(fif.div_by_zero), 32'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    tick(2);

    do_div(32'h40C00000, 32'h40000000, 1'b1, 32'h40400000, 1'b0);
    tick(3);
    do_div(32'h3F800000, 32'h40400000, 1'b1, 32'h3EAAAAAA, 1'b0);
    do_div(32'hC0F00000, 32'h40200000, 1'b1, 32'hC0400000, 1'b0);
    do_div(32'h3F800000, 32'h00000000, 1'b1, 32'h7F800000, 1'b1);
    do_div(32'h00000000, 32'h3F800000, 1'b1, 32'h00000000, 1'b0);
    tick(2);

    // Start and operand changes mid-divide must be ignored.
    fif.start = 1'b1; fif.a = 32'h40C00000; fif.b = 32'h40000000;
    tick(1);
    fif.start = 1'b0;
    tick(4);
    fif.start = 1'b1; fif.a = 32'h3F800000; fif.b = 32'h40400000;
    tick(1);
    fif.start = 1'b0; fif.a = 32'h12345678; fif.b = 32'h00000000;
    wait_done(n);
    check("ignored_latency", 32'(n + 5), 32'd26);
    check("ignored_out", fif.out, 32'h40400000);
    // Back-to-back: start issued in the done cycle.
    do_div(32'hC0F00000, 32'h40200000, 1'b1, 32'hC0400000, 1'b0);

    // Asynchronous reset mid-divide.
    fif.start = 1'b1; fif.a = 32'h3F800000; fif.b = 32'h40400000;
    tick(1);
    fif.start = 1'b0;
    tick(9);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(fif.busy), 32'd0);
    check("abort_done", 32'(fif.done), 32'd0);
    check("abort_out", fif.out, 32'h0);
    tick(3);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (fif.done === 1'b1) seen = 1'b1;
    end
    check("no_done_after_abort", 32'(seen), 32'd0);
    do_div(32'h40C00000, 32'h40000000, 1'b1, 32'h40400000, 1'b0);

    for (int i = 0; i < 60; i++) begin
      ra = $urandom; rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb[30:0] = 31'h0;
        1: ra[30:0] = 31'h0;
        2: begin
          ra[30:23] = 8'($urandom_range(100, 150));
          rb[30:23] = 8'($urandom_range(100, 150));
        end
        default: ;
      endcase
      do_div(ra, rb, 1'b0, 32'h0, 1'b0);
      tick($urandom_range(0, 3));
    end

    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
